// File: rtl/rr_priority_encoder.sv
// Round-robin multi-grant priority encoder: up to PORTS distinct grants per cycle, scanned circularly from a rotating pointer.
// Latency: 1 cycle, from IN_req sampled at an edge to registered outputs after that edge.
// Backpressure: IN_stall=1 holds every register, and the request vector of that cycle is dropped.
module rr_priority_encoder #(
  parameter int LEN   = 16,
  parameter int PORTS = 2,
  localparam int IDXW = (LEN == 1) ? 1 : $clog2(LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN-1:0]        IN_req,
  input  logic                  IN_stall,
  output logic [PORTS*IDXW-1:0] OUT_idx,
  output logic [PORTS*LEN-1:0]  OUT_idxOH,
  output logic [PORTS-1:0]      OUT_valid,
  output logic [IDXW-1:0]       OUT_ptr
);

  logic [IDXW-1:0]       ptr_q;
  logic [IDXW-1:0]       slot_idx [PORTS];
  logic [PORTS-1:0]      slot_vld;
  logic [PORTS*IDXW-1:0] idx_n;
  logic [PORTS*LEN-1:0]  oh_n;
  logic [IDXW-1:0]       ptr_n;
  int                    cnt;
  int                    pos;
  int                    last_i;

  // Circular scan from ptr_q; each set bit fills the next free slot until PORTS slots are used.
  always_comb begin
    slot_vld = '0;
    cnt      = 0;
    pos      = int'(ptr_q);
    for (int p = 0; p < PORTS; p++) slot_idx[p] = '0;
    for (int k = 0; k < LEN; k++) begin
      if (IN_req[pos] && cnt < PORTS) begin
        slot_idx[cnt] = pos[IDXW-1:0];
        slot_vld[cnt] = 1'b1;
        cnt           = cnt + 1;
      end
      // Explicit wrap so non-power-of-two LEN never visits out-of-range indices
      pos = (pos == LEN - 1) ? 0 : pos + 1;
    end
  end

  // Pack slots, build one-hot forms, and advance the pointer just past the last grant.
  always_comb begin
    idx_n  = '0;
    oh_n   = '0;
    last_i = -1;
    for (int p = 0; p < PORTS; p++) begin
      idx_n[p*IDXW +: IDXW] = slot_idx[p];
      if (slot_vld[p]) begin
        oh_n[p*LEN +: LEN] = LEN'(1) << slot_idx[p];
        last_i             = int'(slot_idx[p]);
      end
    end
    if (last_i < 0)
      ptr_n = ptr_q;
    else if (last_i >= LEN - 1)
      ptr_n = '0;
    else
      ptr_n = IDXW'(last_i + 1);
  end

  // Output and pointer registers; stall freezes them all together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      OUT_idx   <= '0;
      OUT_idxOH <= '0;
      OUT_valid <= '0;
      ptr_q     <= '0;
    end else if (!IN_stall) begin
      OUT_idx   <= idx_n;
      OUT_idxOH <= oh_n;
      OUT_valid <= slot_vld;
      ptr_q     <= ptr_n;
    end
  end

  assign OUT_ptr = ptr_q;

  localparam logic [IDXW:0] LEN_W = LEN[IDXW:0];

  // Valid slots always form a contiguous run starting at slot 0.
  a_valid_contig: assert property (@(posedge clk) disable iff (!rst)
    ((OUT_valid & (OUT_valid + 1'b1)) == '0));

  // The pointer never leaves the legal index range.
  a_ptr_range: assert property (@(posedge clk) disable iff (!rst)
    ({1'b0, ptr_q} < LEN_W));

  for (genvar a = 0; a < PORTS; a++) begin : g_chk_a
    // Every reported index is a legal request line.
    a_idx_range: assert property (@(posedge clk) disable iff (!rst)
      ({1'b0, OUT_idx[a*IDXW +: IDXW]} < LEN_W));
    for (genvar b = a + 1; b < PORTS; b++) begin : g_chk_b
      // No request line is granted twice in one cycle.
      a_idx_distinct: assert property (@(posedge clk) disable iff (!rst)
        (!(OUT_valid[a] && OUT_valid[b]) ||
         (OUT_idx[a*IDXW +: IDXW] != OUT_idx[b*IDXW +: IDXW])));
    end
  end

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed bench for rr_priority_encoder with two configurations (LEN=8/PORTS=2 and LEN=6/PORTS=3).
// Inputs change 1 time unit after a rising edge, and outputs are sampled 1 time unit after the next rising edge.
// Ends with a fairness run in which requests stay pending until granted.
module tb_rr_priority_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  req8;
  logic        stall8;
  logic [5:0]  idx8;
  logic [15:0] oh8;
  logic [1:0]  vld8;
  logic [2:0]  ptr8;

  logic [5:0]  req6;
  logic        stall6;
  logic [8:0]  idx6;
  logic [17:0] oh6;
  logic [2:0]  vld6;
  logic [2:0]  ptr6;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rr_priority_encoder #(.LEN(8), .PORTS(2)) u_enc8 (
    .clk(clk), .rst(rst), .IN_req(req8), .IN_stall(stall8),
    .OUT_idx(idx8), .OUT_idxOH(oh8), .OUT_valid(vld8), .OUT_ptr(ptr8)
  );

  rr_priority_encoder #(.LEN(6), .PORTS(3)) u_enc6 (
    .clk(clk), .rst(rst), .IN_req(req6), .IN_stall(stall6),
    .OUT_idx(idx6), .OUT_idxOH(oh6), .OUT_valid(vld6), .OUT_ptr(ptr6)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full observable state of the 8-line encoder
  task automatic expect8(input string tag, input logic [2:0] i0, input logic [2:0] i1,
                         input logic [1:0] v, input logic [7:0] o0, input logic [7:0] o1,
                         input logic [2:0] p);
    check({tag, "_idx0"}, 64'(idx8[2:0]), 64'(i0));
    check({tag, "_idx1"}, 64'(idx8[5:3]), 64'(i1));
    check({tag, "_vld"},  64'(vld8), 64'(v));
    check({tag, "_oh0"},  64'(oh8[7:0]), 64'(o0));
    check({tag, "_oh1"},  64'(oh8[15:8]), 64'(o1));
    check({tag, "_ptr"},  64'(ptr8), 64'(p));
  endtask

  // Full observable state of the 6-line encoder
  task automatic expect6(input string tag, input logic [8:0] idx, input logic [2:0] v,
                         input logic [17:0] oh, input logic [2:0] p);
    check({tag, "_idx"}, 64'(idx6), 64'(idx));
    check({tag, "_vld"}, 64'(vld6), 64'(v));
    check({tag, "_oh"},  64'(oh6), 64'(oh));
    check({tag, "_ptr"}, 64'(ptr6), 64'(p));
  endtask

  logic [7:0] pending;
  logic [7:0] gnt;
  int         age [8];

  initial begin
    rst    = 1'b0;
    req8   = 8'hFF;
    req6   = 6'h3F;
    stall8 = 1'b0;
    stall6 = 1'b0;

    // Reset takes effect with no clock edge
    #2;
    expect8("rst_noclk", 3'd0, 3'd0, 2'b00, 8'h00, 8'h00, 3'd0);
    expect6("rst6_noclk", 9'd0, 3'b000, 18'd0, 3'd0);
    tick();
    tick();
    expect8("rst_held", 3'd0, 3'd0, 2'b00, 8'h00, 8'h00, 3'd0);

    rst  = 1'b1;
    req8 = 8'h26;
    req6 = 6'b000000;
    tick();
    expect8("basic", 3'd1, 3'd2, 2'b11, 8'h02, 8'h04, 3'd3);

    req8 = 8'h26;
    tick();
    expect8("wrap", 3'd5, 3'd1, 2'b11, 8'h20, 8'h02, 3'd2);

    // Stalled cycles drop IN_req and freeze everything
    stall8 = 1'b1;
    req8   = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect8("stall", 3'd5, 3'd1, 2'b11, 8'h20, 8'h02, 3'd2);
    end
    stall8 = 1'b0;
    tick();
    expect8("unstall", 3'd0, 3'd0, 2'b01, 8'h01, 8'h00, 3'd1);

    req8 = 8'h80;
    tick();
    expect8("single_hi", 3'd7, 3'd0, 2'b01, 8'h80, 8'h00, 3'd0);

    req8 = 8'h00;
    tick();
    expect8("idle", 3'd0, 3'd0, 2'b00, 8'h00, 8'h00, 3'd0);

    // Reset asserted while stalled clears asynchronously
    req8 = 8'h26;
    tick();
    stall8 = 1'b1;
    tick();
    check("pre_rst_ptr", 64'(ptr8), 64'd3);
    rst = 1'b0;
    #1;
    expect8("rst_stalled", 3'd0, 3'd0, 2'b00, 8'h00, 8'h00, 3'd0);
    tick();
    rst    = 1'b1;
    stall8 = 1'b0;
    req8   = 8'h81;
    tick();
    expect8("post_rst", 3'd0, 3'd7, 2'b11, 8'h01, 8'h80, 3'd0);

    // Non-power-of-two wrap on the 6-line, 3-port encoder
    req8 = 8'h00;
    req6 = 6'b010000;
    tick();
    expect6("n6_set", {3'd0, 3'd0, 3'd4}, 3'b001, {6'd0, 6'd0, 6'b010000}, 3'd5);
    req6 = 6'b100001;
    tick();
    expect6("n6_wrap", {3'd0, 3'd0, 3'd5}, 3'b011, {6'd0, 6'b000001, 6'b100000}, 3'd1);
    req6 = 6'b000000;
    tick();
    expect6("n6_none", 9'd0, 3'b000, 18'd0, 3'd1);
    req6 = 6'b111111;
    tick();
    expect6("n6_full", {3'd3, 3'd2, 3'd1}, 3'b111, {6'b001000, 6'b000100, 6'b000010}, 3'd4);
    req6 = 6'b111111;
    tick();
    expect6("n6_full_wrap", {3'd0, 3'd5, 3'd4}, 3'b111, {6'b000001, 6'b100000, 6'b010000}, 3'd1);
    req6 = 6'b000000;

    // Fairness: requests persist until granted; each must be served within ceil(8/2)=4 presented cycles
    pending = 8'h00;
    for (int i = 0; i < 8; i++) age[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      pending = pending | 8'($urandom);
      for (int i = 0; i < 8; i++) if (pending[i]) age[i] = age[i] + 1;
      req8 = pending;
      tick();
      gnt = oh8[7:0] | oh8[15:8];
      check("fair_subset", 64'(gnt & ~pending), 64'd0);
      for (int i = 0; i < 8; i++) begin
        if (gnt[i]) begin
          check("fair_age", 64'(age[i] > 4), 64'd0);
          age[i]     = 0;
          pending[i] = 1'b0;
        end
      end
    end
    begin
      int oldest;
      oldest = 0;
      for (int i = 0; i < 8; i++) if (age[i] > oldest) oldest = age[i];
      check("fair_final_age", 64'(oldest > 4), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
